// File: rtl/op_job_dispatcher.sv
// op_job_dispatcher: serial operand loader and start/done sequencer for 8-operand cores.
// Optional build macro: DISPATCH_TIMEOUT_EN enables the done_in wait timeout and the err flag.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ld_valid/ld_data/ld_ready operand word stream (8 words per job)
//   start, i1..i8            one-cycle start pulse and operand buses to core
//   result_in, done_in       core result and completion flag
//   res_valid/res_data/res_ready captured result handshake
//   busy, job_count, err     status: not in LOAD, consumed results, timeout sticky
module op_job_dispatcher #(
  parameter int WIDTH          = 32,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_data,
  output logic             ld_ready,
  output logic             start,
  output logic [WIDTH-1:0] i1,
  output logic [WIDTH-1:0] i2,
  output logic [WIDTH-1:0] i3,
  output logic [WIDTH-1:0] i4,
  output logic [WIDTH-1:0] i5,
  output logic [WIDTH-1:0] i6,
  output logic [WIDTH-1:0] i7,
  output logic [WIDTH-1:0] i8,
  input  logic [WIDTH-1:0] result_in,
  input  logic             done_in,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  input  logic             res_ready,
  output logic             busy,
  output logic [CNT_W-1:0] job_count,
  output logic             err
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_LAUNCH,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t           r_state;
  logic [2:0]       r_idx;
  logic [WIDTH-1:0] r_op [8];
  logic             r_start;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_data;
  logic [CNT_W-1:0] r_jobs;

  logic w_ld_fire;
  logic w_res_fire;
  logic w_tmo;

  assign w_ld_fire  = (r_state == S_LOAD) && ld_valid;
  assign w_res_fire = r_res_valid && res_ready;

`ifdef DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_wcnt;
  logic          r_err;

  // Fires on the last permitted WAIT cycle without done_in.
  assign w_tmo = (r_state == S_WAIT) && !done_in &&
                 (r_wcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == S_LAUNCH) begin
        r_wcnt <= '0;
      end else if (r_state == S_WAIT && !done_in && !w_tmo) begin
        r_wcnt <= r_wcnt + 1'b1;
      end
      if (w_tmo) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  logic [31:0] w_unused_timeout;

  assign w_unused_timeout = TIMEOUT_CYCLES;
  assign w_tmo            = 1'b0;
  assign err              = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_LOAD;
      r_idx       <= '0;
      r_start     <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_jobs      <= '0;
      for (int k = 0; k < 8; k++) begin
        r_op[k] <= '0;
      end
    end else begin
      unique case (r_state)
        S_LOAD: begin
          if (w_ld_fire) begin
            r_op[r_idx] <= ld_data;
            r_idx       <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
              r_state <= S_LAUNCH;
              r_start <= 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          r_start <= 1'b0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (done_in) begin
            r_res_data  <= result_in;
            r_res_valid <= 1'b1;
            r_state     <= S_HOLD;
          end else if (w_tmo) begin
            r_res_data  <= '0;
            r_res_valid <= 1'b1;
            r_state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_res_fire) begin
            r_res_valid <= 1'b0;
            r_jobs      <= r_jobs + 1'b1;
            r_state     <= S_LOAD;
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign ld_ready  = (r_state == S_LOAD);
  assign busy      = (r_state != S_LOAD);
  assign start     = r_start;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign job_count = r_jobs;

  assign i1 = r_op[0];
  assign i2 = r_op[1];
  assign i3 = r_op[2];
  assign i4 = r_op[3];
  assign i5 = r_op[4];
  assign i6 = r_op[5];
  assign i7 = r_op[6];
  assign i8 = r_op[7];

endmodule
